// File: rtl/kamus_pkg.sv
// Shared types for the kamus core memory path.
//   mem_width_e  : access width of a decoded memory op (2'b11 is illegal)
//   lsu_state_e  : load/store sequencer states
//   lsu_err_e    : response error codes returned to writeback
//   is_misaligned: alignment check for a width/offset pair
package kamus_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_width_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    ERR
  } lsu_state_e;

  typedef enum logic [1:0] {
    LSU_OK         = 2'd0,
    LSU_MISALIGNED = 2'd1,
    LSU_BUS_ERR    = 2'd2,
    LSU_TIMEOUT    = 2'd3
  } lsu_err_e;

  // The illegal width encoding is reported the same way as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
    logic bad;
    case (width)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/kamus_lsu_ctrl_if.sv
// Single-port data bus between the LSU and memory.
//   data_req/gnt      : request held until granted
//   data_we/be/addr/wdata : transaction attributes, stable while data_req is high
//   data_rvalid/rdata/err : response (loads and stores); err qualified by rvalid
// Modports: master = LSU side, slave = memory side.
interface kamus_lsu_ctrl_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );
endinterface

// File: rtl/kamus_lsu_align.sv
// Combinational lane logic for the LSU.
//   width, off   : access width and byte offset (addr[1:0])
//   is_unsigned  : zero-extend sub-word loads
//   wdata_in     : LSB-justified store data
//   rdata_in     : raw word from the bus
//   be           : byte enables
//   lane_wdata   : store data replicated across lanes
//   load_data    : selected and extended load result
module kamus_lsu_align
  import kamus_pkg::*;
(
  input  mem_width_e  width,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = '0;
    lane_wdata = '0;
    load_data  = '0;
    case (off)
      2'd0:    byte_sel = rdata_in[7:0];
      2'd1:    byte_sel = rdata_in[15:8];
      2'd2:    byte_sel = rdata_in[23:16];
      default: byte_sel = rdata_in[31:24];
    endcase
    half_sel = off[1] ? rdata_in[31:16] : rdata_in[15:0];
    case (width)
      MEM_B: begin
        be         = 4'b0001 << off;
        lane_wdata = {4{wdata_in[7:0]}};
        load_data  = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        be         = 4'b0011 << off;
        lane_wdata = {2{wdata_in[15:0]}};
        load_data  = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      MEM_W: begin
        be         = 4'b1111;
        lane_wdata = wdata_in;
        load_data  = rdata_in;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/kamus_lsu_ctrl.sv
// Load/store sequencer between EX and the single-port data bus.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   req_*                  : one decoded memory op from EX (valid/ready)
//   kill_i                 : pipeline flush, aborts the current op
//   rsp_valid/rdata/err_o  : one-cycle completion pulse to writeback
//   busy_o                 : high whenever not IDLE
//   bus                    : data bus master port
module kamus_lsu_ctrl
  import kamus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_width_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        kill_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o,
  output logic        busy_o,
  kamus_lsu_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e       state_q, state_d;
  mem_width_e       op_width_q, op_width_d;
  logic [1:0]       op_off_q, op_off_d;
  logic             op_unsigned_q, op_unsigned_d;
  logic             op_we_q, op_we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             timeout;

  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  lsu_err_e         rsp_err_q, rsp_err_d;

  mem_width_e       al_width;
  logic [1:0]       al_off;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata, al_load;

  // One aligner serves both directions: in IDLE it shapes the incoming store
  // lanes/enables; afterwards it extracts load data for the captured op.
  assign al_width = (state_q == IDLE) ? mem_width_e'(req_width_i) : op_width_q;
  assign al_off   = (state_q == IDLE) ? req_addr_i[1:0] : op_off_q;

  kamus_lsu_align u_align (
    .width       (al_width),
    .off         (al_off),
    .is_unsigned (op_unsigned_q),
    .wdata_in    (req_wdata_i),
    .rdata_in    (bus.data_rdata),
    .be          (al_be),
    .lane_wdata  (al_wdata),
    .load_data   (al_load)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_MAX);

  always_comb begin
    state_d       = state_q;
    op_width_d    = op_width_q;
    op_off_d      = op_off_q;
    op_unsigned_d = op_unsigned_q;
    op_we_d       = op_we_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    be_d          = be_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = LSU_OK;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && !kill_i) begin
          op_width_d    = mem_width_e'(req_width_i);
          op_off_d      = req_addr_i[1:0];
          op_unsigned_d = req_unsigned_i;
          op_we_d       = req_we_i;
          if (is_misaligned(req_width_i, req_addr_i[1:0])) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = req_we_i;
            be_d    = al_be;
            addr_d  = {req_addr_i[31:2], 2'b00};
            wdata_d = al_wdata;
          end
        end
      end
      REQ: begin
        if (bus.data_gnt || kill_i) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = '0;
          // A granted transaction must still be drained even when killed.
          if (bus.data_gnt) state_d = kill_i ? DRAIN : WAIT;
          else              state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (kill_i) begin
          state_d = (bus.data_rvalid || timeout) ? IDLE : DRAIN;
        end else if (bus.data_rvalid) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          if (bus.data_err)  rsp_err_d   = LSU_BUS_ERR;
          else if (!op_we_q) rsp_rdata_d = al_load;
        end else if (timeout) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = LSU_TIMEOUT;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (bus.data_rvalid || timeout) state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
        if (!kill_i) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = LSU_MISALIGNED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      op_width_q    <= MEM_B;
      op_off_q      <= '0;
      op_unsigned_q <= 1'b0;
      op_we_q       <= 1'b0;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      be_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= LSU_OK;
    end else begin
      state_q       <= state_d;
      op_width_q    <= op_width_d;
      op_off_q      <= op_off_d;
      op_unsigned_q <= op_unsigned_d;
      op_we_q       <= op_we_d;
      cnt_q         <= cnt_d;
      req_q         <= req_d;
      we_q          <= we_d;
      be_q          <= be_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_o      = rsp_err_q;
  assign bus.data_req   = req_q;
  assign bus.data_we    = we_q;
  assign bus.data_be    = be_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
module tb_kamus_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        kill = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;

  kamus_lsu_ctrl_if bus_if ();

  kamus_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_width_i    (req_width),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .kill_i         (kill),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .busy_o         (busy),
    .bus            (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rdata=%h err=%0d at cyc %0d want none", rsp_rdata, rsp_err, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {30'b0, rsp_err}, {30'b0, e.err});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end else begin
        chk("rsp_idle_zero", rsp_rdata | {30'b0, rsp_err}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic [1:0] er, input int unsigned c);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [1:0] w, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    chk("ready_before_issue", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_width = w; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  // Aligned op: gnt in the first REQ cycle, rvalid on the next cycle.
  task automatic run_op(input logic we, input logic [1:0] w, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] rd, input logic rerr,
                        input logic [31:0] exp_rd, input logic [1:0] exp_err);
    issue(we, w, uns, a, wd);
    chk("data_req", {31'b0, bus_if.data_req}, 32'd1);
    chk("data_be", {28'b0, bus_if.data_be}, {28'b0, exp_be});
    chk("data_addr", bus_if.data_addr, {a[31:2], 2'b00});
    chk("data_we", {31'b0, bus_if.data_we}, {31'b0, we});
    if (we) chk("data_wdata", bus_if.data_wdata, exp_wd);
    bus_if.data_gnt = 1'b1;
    tick();
    bus_if.data_gnt = 1'b0;
    chk("req_dropped", {31'b0, bus_if.data_req}, 32'd0);
    bus_if.data_rvalid = 1'b1; bus_if.data_rdata = rd; bus_if.data_err = rerr;
    push(exp_rd, exp_err, cyc + 1);
    tick();
    bus_if.data_rvalid = 1'b0; bus_if.data_err = 1'b0;
    chk("ready_in_rsp_cycle", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.data_gnt = 1'b0; bus_if.data_rvalid = 1'b0;
    bus_if.data_rdata = '0; bus_if.data_err = 1'b0;
    repeat (3) tick();
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req", {31'b0, bus_if.data_req}, 32'd0);
    chk("rst_be_addr", bus_if.data_addr | {28'b0, bus_if.data_be}, 32'd0);
    rst = 1'b0;
    tick();

    // Loads and stores through the aligner
    run_op(0, 2'b10, 0, 32'h100, 0, 4'b1111, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2'd0);
    run_op(0, 2'b00, 0, 32'h103, 0, 4'b1000, 0, 32'h80FFFF7F, 0, 32'hFFFFFF80, 2'd0);
    run_op(0, 2'b00, 1, 32'h103, 0, 4'b1000, 0, 32'h80FFFF7F, 0, 32'h00000080, 2'd0);
    run_op(0, 2'b01, 0, 32'h102, 0, 4'b1100, 0, 32'h80FFFF7F, 0, 32'hFFFF80FF, 2'd0);
    run_op(0, 2'b01, 1, 32'h102, 0, 4'b1100, 0, 32'h80FFFF7F, 0, 32'h000080FF, 2'd0);
    run_op(0, 2'b00, 0, 32'h101, 0, 4'b0010, 0, 32'h1234F6AB, 0, 32'hFFFFFFF6, 2'd0);
    run_op(1, 2'b01, 0, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 32'h55555555, 0, 0, 2'd0);
    run_op(1, 2'b00, 0, 32'h201, 32'hCAFE0077, 4'b0010, 32'h77777777, 32'h55555555, 0, 0, 2'd0);
    run_op(0, 2'b10, 0, 32'h400, 0, 4'b1111, 0, 32'h12345678, 1, 0, 2'd2);

    // Misaligned word and illegal width: no bus access, response at N+2
    push(0, 2'd1, cyc + 2);
    issue(0, 2'b10, 0, 32'h101, 0);
    chk("mis_no_req0", {31'b0, bus_if.data_req}, 32'd0);
    tick();
    chk("mis_no_req1", {31'b0, bus_if.data_req}, 32'd0);
    push(0, 2'd1, cyc + 2);
    issue(0, 2'b11, 0, 32'h100, 0);
    tick();
    push(0, 2'd1, cyc + 2);
    issue(0, 2'b01, 1, 32'h203, 0);
    tick();

    // Grant withheld 5 cycles, then no rvalid -> timeout
    issue(0, 2'b10, 0, 32'h300, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", {31'b0, bus_if.data_req}, 32'd1);
      chk("hold_addr", bus_if.data_addr, 32'h300);
      chk("hold_be", {28'b0, bus_if.data_be}, 32'hF);
      tick();
    end
    bus_if.data_gnt = 1'b1;
    push(0, 2'd3, cyc + 5);
    tick();
    bus_if.data_gnt = 1'b0;
    repeat (6) tick();

    // rvalid exactly TIMEOUT_CYCLES after gnt is still a normal completion
    issue(0, 2'b10, 0, 32'h500, 0);
    bus_if.data_gnt = 1'b1;
    push(32'hA5A5_0F0F, 2'd0, cyc + 5);
    tick();
    bus_if.data_gnt = 1'b0;
    repeat (3) tick();
    bus_if.data_rvalid = 1'b1; bus_if.data_rdata = 32'hA5A5_0F0F;
    tick();
    bus_if.data_rvalid = 1'b0;
    tick();

    // kill in WAIT, rvalid three cycles later: busy until rvalid, no response
    issue(0, 2'b10, 0, 32'h600, 0);
    bus_if.data_gnt = 1'b1;
    tick();
    bus_if.data_gnt = 1'b0;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("drain_busy0", {31'b0, busy}, 32'd1);
    tick();
    chk("drain_busy1", {31'b0, busy}, 32'd1);
    bus_if.data_rvalid = 1'b1;
    tick();
    bus_if.data_rvalid = 1'b0;
    chk("drain_done", {31'b0, busy}, 32'd0);
    tick();

    // kill in REQ without gnt -> IDLE, request dropped
    issue(0, 2'b10, 0, 32'h700, 0);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_req_drop", {31'b0, bus_if.data_req}, 32'd0);
    chk("kill_req_idle", {31'b0, busy}, 32'd0);

    // kill together with gnt -> DRAIN, response swallowed
    issue(0, 2'b10, 0, 32'h704, 0);
    kill = 1'b1; bus_if.data_gnt = 1'b1;
    tick();
    kill = 1'b0; bus_if.data_gnt = 1'b0;
    chk("kill_gnt_drain", {31'b0, busy}, 32'd1);
    bus_if.data_rvalid = 1'b1;
    tick();
    bus_if.data_rvalid = 1'b0;
    chk("kill_gnt_idle", {31'b0, busy}, 32'd0);
    tick();

    // kill in ERR suppresses the misaligned response
    issue(0, 2'b10, 0, 32'h102, 0);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_err_idle", {31'b0, busy}, 32'd0);
    tick();

    // kill in IDLE blocks the accept
    req_valid = 1'b1; req_width = 2'b10; req_addr = 32'h800; kill = 1'b1;
    tick();
    req_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_block", {31'b0, busy}, 32'd0);

    // Reset mid-REQ: outputs clear immediately, stale rvalid ignored
    issue(0, 2'b10, 0, 32'h900, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'b0, bus_if.data_req}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_addr", bus_if.data_addr, 32'd0);
    tick();
    rst = 1'b0;
    bus_if.data_rvalid = 1'b1;
    tick();
    bus_if.data_rvalid = 1'b0;
    repeat (3) tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
